// File: rtl/modulator_pkg.sv
// modulator_pkg: shared scheduler state type and default frame/fill constants.
package modulator_pkg;
    typedef enum logic [1:0] {S_IDLE, S_ARB, S_PRE, S_DATA} sched_state_t;
    localparam logic [7:0] IDLE_SAMPLE_DEF = 8'h80;
    localparam int PREAMBLE_LEN_DEF = 16;
    localparam int FRAME_LEN_DEF = 256;
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/am_sample_scheduler_if.sv
// am_sample_scheduler_if: source FIFO heads, modulator read port and scheduler status.
interface am_sample_scheduler_if #(parameter int BITS_PER_SAMPLE = 8);
    logic [BITS_PER_SAMPLE-1:0] src0_sample, src1_sample, mod_sample;
    logic src0_empty, src1_empty, src0_read, src1_read;
    logic mod_read, mod_empty, frame_start, active_src;
    logic [15:0] underflow_cnt;
    modport master (
        input  src0_sample, src1_sample, src0_empty, src1_empty, mod_read,
        output src0_read, src1_read, mod_sample, mod_empty, frame_start, active_src, underflow_cnt
    );
    modport slave (
        output src0_sample, src1_sample, src0_empty, src1_empty, mod_read,
        input  src0_read, src1_read, mod_sample, mod_empty, frame_start, active_src, underflow_cnt
    );
endinterface

// File: rtl/am_sched_arbiter.sv
// am_sched_arbiter: two-way round-robin grant, preferring the source not served last.
module am_sched_arbiter (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant
);
    assign grant = req[~last_grant] ? ~last_grant : last_grant;
endmodule

// File: rtl/am_sample_scheduler.sv
// am_sample_scheduler: frames preamble fill plus source samples into a modulator read stream.
// Optional underflow counter enabled by defining AM_SCHED_UNDERFLOW_CNT_EN.
module am_sample_scheduler
    import modulator_pkg::*;
#(
    parameter int BITS_PER_SAMPLE = 8,
    parameter int PREAMBLE_LEN = PREAMBLE_LEN_DEF,
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter logic [BITS_PER_SAMPLE-1:0] IDLE_SAMPLE = BITS_PER_SAMPLE'(IDLE_SAMPLE_DEF)
) (
    input logic clk,
    input logic rst,
    input logic enable,
    am_sample_scheduler_if.master bus
);
    localparam int PW = cnt_w(PREAMBLE_LEN);
    localparam int FW = cnt_w(FRAME_LEN);
    localparam logic [PW-1:0] P_LAST = PW'(PREAMBLE_LEN - 1);
    localparam logic [FW-1:0] F_LAST = FW'(FRAME_LEN - 1);

    sched_state_t r_state;
    logic r_rd_q, r_active, r_empty, r_fstart;
    logic [PW-1:0] r_pcnt;
    logic [FW-1:0] r_fcnt;
    logic [BITS_PER_SAMPLE-1:0] r_sample;
    logic w_pop, w_grant, w_src_empty, w_take;
    logic [1:0] w_req;
    logic [BITS_PER_SAMPLE-1:0] w_src_sample;

    assign w_pop = bus.mod_read & ~r_rd_q;
    assign w_req = {~bus.src1_empty, ~bus.src0_empty};
    assign w_src_empty = r_active ? bus.src1_empty : bus.src0_empty;
    assign w_src_sample = r_active ? bus.src1_sample : bus.src0_sample;
    // a disabled cycle never pops a source, even on a read edge
    assign w_take = enable & w_pop & (r_state == S_DATA) & ~w_src_empty;
    assign bus.src0_read = w_take & ~r_active;
    assign bus.src1_read = w_take & r_active;
    assign bus.mod_sample = r_sample;
    assign bus.mod_empty = r_empty;
    assign bus.frame_start = r_fstart;
    assign bus.active_src = r_active;

    am_sched_arbiter u_arb (.req(w_req), .last_grant(r_active), .grant(w_grant));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_rd_q   <= 1'b0;
            r_active <= 1'b1;
            r_empty  <= 1'b1;
            r_fstart <= 1'b0;
            r_pcnt   <= '0;
            r_fcnt   <= '0;
            r_sample <= IDLE_SAMPLE;
        end else begin
            r_rd_q   <= bus.mod_read;
            r_fstart <= 1'b0;
            if (!enable) begin
                r_state  <= S_IDLE;
                r_empty  <= 1'b1;
                r_sample <= IDLE_SAMPLE;
                r_pcnt   <= '0;
                r_fcnt   <= '0;
            end else begin
                if (w_pop && r_state != S_IDLE)
                    r_sample <= w_take ? w_src_sample : IDLE_SAMPLE;
                case (r_state)
                    S_IDLE: begin
                        r_state <= S_ARB;
                        r_empty <= 1'b0;
                    end
                    S_ARB: if (|w_req) begin
                        r_active <= w_grant;
                        r_state  <= (PREAMBLE_LEN == 0) ? S_DATA : S_PRE;
                        r_fstart <= (PREAMBLE_LEN == 0);
                        r_pcnt   <= '0;
                        r_fcnt   <= '0;
                    end
                    S_PRE: if (w_pop) begin
                        r_pcnt   <= (r_pcnt == P_LAST) ? '0 : r_pcnt + 1'b1;
                        r_state  <= (r_pcnt == P_LAST) ? S_DATA : S_PRE;
                        r_fstart <= (r_pcnt == P_LAST);
                    end
                    S_DATA: if (w_pop) begin
                        r_fcnt  <= (r_fcnt == F_LAST) ? '0 : r_fcnt + 1'b1;
                        r_state <= (r_fcnt == F_LAST) ? S_ARB : S_DATA;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

`ifdef AM_SCHED_UNDERFLOW_CNT_EN
    logic [15:0] r_under;
    logic w_under;
    assign w_under = enable & w_pop & (r_state == S_DATA) & w_src_empty;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_under <= '0;
        else if (w_under && r_under != 16'hFFFF)
            r_under <= r_under + 16'd1;
    end
    assign bus.underflow_cnt = r_under;
`else
    assign bus.underflow_cnt = '0;
`endif
endmodule
